// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side bundle of the transmitter (FIFO write, line control, 16x strobe, status and line).
interface uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    logic [7:0] lcr;
    logic tf_push;
    logic [7:0] wb_dat_i;
    logic enable;
    logic tx_reset;
    logic lsr_mask;
    logic stx_pad_o;
    logic [2:0] tstate;
    logic [$clog2(FIFO_DEPTH):0] tf_count;
    modport master (
        output lcr, tf_push, wb_dat_i, enable, tx_reset, lsr_mask,
        input stx_pad_o, tstate, tf_count
    );
    modport slave (
        input lcr, tf_push, wb_dat_i, enable, tx_reset, lsr_mask,
        output stx_pad_o, tstate, tf_count
    );
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: 16550-style serial transmitter with an internal transmit FIFO.
// Frames are timed by a 16x baud enable strobe and formatted from an LCR-style byte.
module uart_tx_core #(
    parameter int FIFO_DEPTH = 16
) (
    input logic CLK,
    input logic RST,
    uart_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, POP = 3'd5
    } state_t;
    state_t state;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [7:0] shift, head;
    logic [2:0] bit_cnt;
    logic [4:0] tick_cnt, last_tick;
    logic [2:0] fmt;  // {stick, even, two_stop}, refreshed only at bit-period boundaries
    logic parity_xor, short_word, overrun, line, par_bit, push, pop, full, wrap, unused;
    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign push = bus.tf_push && !full;
    assign pop = bus.enable && state == POP && count != '0;
    assign head = mem[rd_ptr];
    assign last_tick = (state == STOP && fmt[0]) ? (short_word ? 5'd23 : 5'd31) : 5'd15;
    assign wrap = tick_cnt == last_tick;
    assign par_bit = fmt[2] ? ~fmt[1] : ~(parity_xor ^ fmt[1]);
    assign unused = bus.lcr[7];
    assign bus.tstate = state;
    assign bus.tf_count = count;
    always_comb line = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_bit : 1'b1;
    always_ff @(posedge CLK) if (push && !bus.tx_reset) mem[wr_ptr] <= bus.wb_dat_i;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (bus.tx_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == AW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == AW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) overrun <= 1'b0;
        else if (bus.lsr_mask) overrun <= 1'b0;
        else if (bus.tf_push && full) overrun <= 1'b1;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            shift <= '0;
            bit_cnt <= '0;
            tick_cnt <= '0;
            fmt <= '0;
            parity_xor <= 1'b0;
            short_word <= 1'b0;
        end else if (bus.enable) begin
            tick_cnt <= (state inside {START, DATA, PARITY, STOP} && !wrap) ? tick_cnt + 1'b1 : '0;
            if (wrap || state == POP) fmt <= {bus.lcr[5:4], bus.lcr[2]};
            case (state)
                IDLE: if (count != '0) state <= POP;
                POP: begin
                    if (count != '0) begin
                        shift <= head;
                        bit_cnt <= {1'b1, bus.lcr[1:0]};
                        parity_xor <= ^(head & (8'hff >> (2'd3 - bus.lcr[1:0])));
                        short_word <= bus.lcr[1:0] == 2'd0;
                        state <= START;
                    end else state <= IDLE;
                end
                START: if (wrap) state <= DATA;
                DATA: begin
                    if (wrap) begin
                        shift <= shift >> 1;
                        bit_cnt <= bit_cnt - 1'b1;
                        if (bit_cnt == '0) state <= bus.lcr[3] ? PARITY : STOP;
                    end
                end
                PARITY: if (wrap) state <= STOP;
                STOP: if (wrap) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) bus.stx_pad_o <= 1'b1;
        else bus.stx_pad_o <= bus.lcr[6] ? 1'b0 : line;
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: random-byte, random-format frames checked against a per-enable line model.
module tb_uart_tx_core;
    logic CLK = 1'b0, RST = 1'b1;
    logic en_on = 1'b0, man_en = 1'b0, auto_en = 1'b0;
    int n_vec = 0, n_err = 0, gap = 0, z = 0;
    logic rx_q[$];
    logic [2:0] st_q[$];
    logic [7:0] d0, d1, d2, l;
    logic [191:0] bits;
    int len;
    uart_tx_if bus();
    uart_tx_core dut (.CLK(CLK), .RST(RST), .bus(bus));
    assign bus.enable = en_on ? auto_en : man_en;
    always #5 CLK = ~CLK;
    initial forever begin
        @(posedge CLK);
        #1;
        auto_en = gap == 0;
        gap = gap == 0 ? $urandom_range(3, 1) : gap - 1;
    end
    // Each enable sees the line and state that the FSM is acting on in that strobe.
    always @(negedge CLK) if (bus.enable) begin
        rx_q.push_back(bus.stx_pad_o);
        st_q.push_back(bus.tstate);
    end
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic push(input logic [7:0] d);
        bus.tf_push = 1'b1;
        bus.wb_dat_i = d;
        step();
        bus.tf_push = 1'b0;
    endtask
    task automatic flush();
        rx_q.delete();
        st_q.delete();
    endtask
    task automatic wait_state(input logic [2:0] s);
        int b = 4000;
        while (bus.tstate !== s && b > 0) begin
            step();
            b--;
        end
        chk("wait_state", b > 0, 1);
    endtask
    function automatic int emit(inout logic [191:0] v, input int pos, input logic b, input int n);
        for (int i = 0; i < n; i++) v[pos + i] = b;
        return pos + n;
    endfunction
    function automatic void exp_frame(input logic [7:0] d, input logic [7:0] f, output logic [191:0] v, output int n);
        int wl;
        logic p;
        wl = 5 + int'(f[1:0]);
        p = ^(d & (8'hff >> (8 - wl)));
        v = '1;
        n = 0;
        n = emit(v, n, 1'b0, 16);
        for (int i = 0; i < wl; i++) n = emit(v, n, d[i], 16);
        if (f[3]) n = emit(v, n, f[5] ? !f[4] : (f[4] ? p : !p), 16);
        n = emit(v, n, 1'b1, f[2] ? (wl == 5 ? 24 : 32) : 16);
    endfunction
    task automatic get_frame(output logic [191:0] v, output int n);
        int budget = 8000;
        bit started = 0, done = 0;
        logic [2:0] s;
        logic b;
        v = '1;
        n = 0;
        while (!done && budget > 0) begin
            if (st_q.size() == 0) begin
                step();
                budget--;
            end else begin
                s = st_q.pop_front();
                b = rx_q.pop_front();
                if (s inside {[3'd1:3'd4]}) begin
                    started = 1;
                    if (n < 192) v[n] = b;
                    n++;
                end else if (started) done = 1;
            end
        end
        chk("frame_done", done, 1);
    endtask
    task automatic check_frame(input string tag, input logic [7:0] d, input logic [7:0] f);
        logic [191:0] ev, gv;
        int en, gn;
        exp_frame(d, f, ev, en);
        get_frame(gv, gn);
        chk({tag, "_len"}, gn, en);
        chk({tag, "_bits"}, gv, ev);
    endtask
    initial begin
        bus.lcr = 8'h03;
        bus.tf_push = 1'b0;
        bus.wb_dat_i = '0;
        bus.tx_reset = 1'b0;
        bus.lsr_mask = 1'b0;
        step(3);
        chk("rst_stx", bus.stx_pad_o, 1);
        chk("rst_tstate", bus.tstate, 0);
        chk("rst_count", bus.tf_count, 0);
        RST = 1'b0;
        en_on = 1'b1;
        step(60);
        foreach (rx_q[i]) z += rx_q[i] ? 0 : 1;
        chk("idle_line_zeros", z, 0);
        chk("idle_state", bus.tstate, 0);
        flush();
        push(8'h55);
        chk("push_count", bus.tf_count, 1);
        check_frame("8n1", 8'h55, 8'h03);
        chk("8n1_count_after", bus.tf_count, 0);
        chk("8n1_idle_after", bus.tstate, 0);
        en_on = 1'b0;
        step(2);
        flush();
        for (int i = 0; i < 17; i++) push(8'(i));
        chk("fifo_full_count", bus.tf_count, 16);
        bus.lsr_mask = 1'b1;
        step();
        bus.lsr_mask = 1'b0;
        en_on = 1'b1;
        for (int i = 0; i < 16; i++) check_frame("fifo", 8'(i), 8'h03);
        step(600);
        chk("fifo_drained", bus.tf_count, 0);
        z = 0;
        foreach (st_q[i]) z += st_q[i] == 3'd1 ? 1 : 0;
        chk("fifo_17th_lost", z, 0);
        bus.lcr = 8'h1B;
        push(8'h07);
        check_frame("even_par", 8'h07, 8'h1B);
        bus.lcr = 8'h0B;
        push(8'h07);
        check_frame("odd_par", 8'h07, 8'h0B);
        d0 = 8'($urandom);
        bus.lcr = 8'h07;
        push(d0);
        check_frame("two_stop", d0, 8'h07);
        d0 = 8'($urandom);
        bus.lcr = 8'h04;
        push(d0);
        check_frame("five_stop", d0, 8'h04);
        repeat (8) begin
            l = 8'($urandom) & 8'h3F;
            d0 = 8'($urandom);
            bus.lcr = l;
            push(d0);
            check_frame("rand", d0, l);
        end
        bus.lcr = 8'h03;
        flush();
        push(8'($urandom));
        wait_state(3'd2);
        bus.lcr = 8'h43;
        step();
        chk("break_line", bus.stx_pad_o, 0);
        get_frame(bits, len);
        chk("break_len", len, 160);
        bus.lcr = 8'h03;
        step();
        chk("break_release", bus.stx_pad_o, 1);
        flush();
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        push(d0);
        push(d1);
        push(d2);
        wait_state(3'd2);
        chk("txr_count_before", bus.tf_count, 2);
        bus.tx_reset = 1'b1;
        step();
        bus.tx_reset = 1'b0;
        chk("txr_count", bus.tf_count, 0);
        check_frame("txr_inflight", d0, 8'h03);
        step(600);
        z = 0;
        foreach (st_q[i]) z += st_q[i] == 3'd1 ? 1 : 0;
        chk("txr_no_more", z, 0);
        en_on = 1'b0;
        step(2);
        flush();
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        push(d0);
        man_en = 1'b1;
        step();
        man_en = 1'b0;
        chk("pp_pop_state", bus.tstate, 5);
        step();
        man_en = 1'b1;
        bus.tf_push = 1'b1;
        bus.wb_dat_i = d1;
        step();
        man_en = 1'b0;
        bus.tf_push = 1'b0;
        chk("pp_count", bus.tf_count, 1);
        chk("pp_start", bus.tstate, 1);
        step();
        en_on = 1'b1;
        check_frame("pp_a", d0, 8'h03);
        check_frame("pp_b", d1, 8'h03);
        flush();
        push(8'($urandom));
        push(8'($urandom));
        wait_state(3'd2);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_stx", bus.stx_pad_o, 1);
        chk("arst_state", bus.tstate, 0);
        chk("arst_count", bus.tf_count, 0);
        step();
        RST = 1'b0;
        step(50);
        chk("arst_stays_idle", bus.tstate, 0);
        chk("arst_line_high", bus.stx_pad_o, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
